// File: rtl/ad7760_pkg.sv
// Shared types and constants for the AD7760 stream controller: FSM states,
// default control-register writes and the packing of the 32-bit FIFO word.
package ad7760_pkg;

    typedef enum logic [3:0] {
        ST_RST_PULSE,
        ST_RST_WAIT,
        ST_WR_ADDR,
        ST_WR_GAP,
        ST_WR_VAL,
        ST_SETTLE,
        ST_IDLE,
        ST_WAIT_DRDY,
        ST_RD_HI,
        ST_RD_GAP,
        ST_RD_LO,
        ST_PUSH
    } state_e;

    localparam int CNT_W = 16;

    localparam logic [15:0] CR1_ADDR = 16'h0001;
    localparam logic [15:0] CR1_DEF  = 16'h0000;
    localparam logic [15:0] CR2_ADDR = 16'h0002;
    localparam logic [15:0] CR2_DEF  = 16'h0022;
    localparam logic [63:0] CFG_DEFAULT = {CR1_ADDR, CR1_DEF, CR2_ADDR, CR2_DEF};

    localparam int FD_SAMPLE_LSB = 8;
    localparam int FD_SAMPLE_W   = 24;
    localparam int FD_STATUS_LSB = 0;
    localparam int FD_STATUS_W   = 8;

    function automatic logic [31:0] pack_word(input logic [FD_SAMPLE_W-1:0] sample,
                                              input logic [FD_STATUS_W-1:0] status);
        logic [31:0] w;
        w = '0;
        w[FD_SAMPLE_LSB +: FD_SAMPLE_W] = sample;
        w[FD_STATUS_LSB +: FD_STATUS_W] = status;
        return w;
    endfunction

endpackage

// File: rtl/ad7760_bus_strobe.sv
// Cycle timer shared by every timed controller state; restarts on clr_i and
// flags the first and last cycle of a len_i-cycle interval.
module ad7760_bus_strobe
    import ad7760_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             first_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr_i ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign first_o = (cnt_q == '0);
    assign done_o  = (cnt_q == len_i - 1'b1);

endmodule

// File: rtl/ad7760_stream_ctrl.sv
// AD7760 controller: reset pulse, control-register writes, then streams
// 24-bit samples plus status into a FIFO on each synchronised DRDY edge.
module ad7760_stream_ctrl
    import ad7760_pkg::*;
#(
    parameter int                     NUM_CFG     = 2,
    parameter logic [NUM_CFG*32-1:0]  CFG_TABLE   = CFG_DEFAULT,
    parameter int                     RST_LOW_CYC = 4,
    parameter int                     STROBE_CYC  = 8,
    parameter int                     SETTLE_CYC  = 6
) (
    input  logic        mclk,
    input  logic        i_rest_n,
    input  logic        command,
    input  logic        drdy_n,
    input  logic [15:0] db_in,
    output logic [15:0] db_out,
    output logic        db_oe,
    output logic        r_n_w,
    output logic        cs_n,
    output logic        o_rest_n,
    output logic [31:0] fifo_data,
    output logic        wrreq,
    input  logic        fifo_full,
    output logic        cfg_done,
    output logic        overrun,
    output logic [15:0] sample_cnt
);

    localparam int NWORDS = 2 * NUM_CFG;
    localparam logic [CNT_W-1:0] RST_LEN    = CNT_W'(RST_LOW_CYC);
    localparam logic [CNT_W-1:0] STB_LEN    = CNT_W'(STROBE_CYC);
    localparam logic [CNT_W-1:0] SETTLE_LEN = CNT_W'(SETTLE_CYC);

    function automatic logic [15:0] cfg_word(input logic [4:0] idx);
        int sh;
        sh = (NWORDS - 1 - int'(idx)) * 16;
        return CFG_TABLE[sh +: 16];
    endfunction

    state_e state_q, state_d;
    logic [4:0]  wr_idx_q, wr_idx_d, next_idx;
    logic [15:0] hi_q, hi_d;
    logic        sync1_q, sync2_q, sync3_q, drdy_fall;
    logic        tmr_first, tmr_done;
    logic [CNT_W-1:0] tmr_len;
    logic        push, in_read;

    logic [15:0] db_out_q, db_out_d;
    logic        db_oe_q, db_oe_d, r_n_w_q, r_n_w_d, cs_n_q, cs_n_d;
    logic        o_rest_n_q, o_rest_n_d;
    logic [31:0] fifo_data_q, fifo_data_d;
    logic        wrreq_q, wrreq_d, cfg_done_q, cfg_done_d, overrun_q, overrun_d;
    logic [15:0] sample_cnt_q, sample_cnt_d;

    assign drdy_fall = sync3_q & ~sync2_q;

    always_comb begin
        case (state_q)
            ST_RST_PULSE, ST_RST_WAIT: tmr_len = RST_LEN;
            ST_SETTLE:                 tmr_len = SETTLE_LEN;
            default:                   tmr_len = STB_LEN;
        endcase
    end

    ad7760_bus_strobe u_strobe (
        .clk     (mclk),
        .rst_n   (i_rest_n),
        .clr_i   (state_d != state_q),
        .len_i   (tmr_len),
        .first_o (tmr_first),
        .done_o  (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        case (state_q)
            ST_RST_PULSE: if (tmr_done) state_d = ST_RST_WAIT;
            ST_RST_WAIT:  if (tmr_done) state_d = ST_WR_ADDR;
            ST_WR_ADDR,
            ST_WR_VAL:    if (tmr_done) state_d = ST_WR_GAP;
            ST_WR_GAP: begin
                if (tmr_done) begin
                    wr_idx_d = wr_idx_q + 5'd1;
                    if (wr_idx_q == 5'(NWORDS - 1)) state_d = ST_SETTLE;
                    else if (!wr_idx_q[0])          state_d = ST_WR_VAL;
                    else                            state_d = ST_WR_ADDR;
                end
            end
            ST_SETTLE:    if (tmr_done) state_d = ST_IDLE;
            ST_IDLE:      if (command) state_d = ST_WAIT_DRDY;
            ST_WAIT_DRDY: begin
                if (!command)       state_d = ST_IDLE;
                else if (drdy_fall) state_d = ST_RD_HI;
            end
            ST_RD_HI:     if (tmr_done) state_d = ST_RD_GAP;
            ST_RD_GAP:    if (tmr_done) state_d = ST_RD_LO;
            ST_RD_LO:     if (tmr_done) state_d = ST_PUSH;
            ST_PUSH:      state_d = command ? ST_WAIT_DRDY : ST_IDLE;
            default:      state_d = ST_RST_PULSE;
        endcase
    end

    // Bus pins decode from the next state so they change on the same edge as the FSM.
    always_comb begin
        o_rest_n_d = (state_d != ST_RST_PULSE);
        cs_n_d     = !(state_d inside {ST_WR_ADDR, ST_WR_VAL, ST_RD_HI, ST_RD_LO});
        r_n_w_d    = !(state_d inside {ST_WR_ADDR, ST_WR_GAP, ST_WR_VAL});
        db_oe_d    = (state_d inside {ST_RST_WAIT, ST_WR_ADDR, ST_WR_GAP, ST_WR_VAL});
    end

    // The next table word is loaded after the first gap cycle, so it is held one
    // cycle past the previous cs_n rise and set up before the next cs_n fall.
    assign next_idx = (state_q == ST_RST_WAIT) ? 5'd0 : wr_idx_q + 5'd1;

    always_comb begin
        db_out_d = db_out_q;
        if ((state_q == ST_RST_WAIT || state_q == ST_WR_GAP) && tmr_first &&
            int'(next_idx) < NWORDS)
            db_out_d = cfg_word(next_idx);
    end

    // fifo_full is sampled on the edge into PUSH so wrreq can stay registered.
    assign push    = (state_q == ST_RD_LO) && tmr_done;
    assign in_read = (state_q inside {ST_RD_HI, ST_RD_GAP, ST_RD_LO, ST_PUSH});

    always_comb begin
        hi_d         = (state_q == ST_RD_HI && tmr_done) ? db_in : hi_q;
        fifo_data_d  = push ? pack_word({hi_q, db_in[15:8]}, db_in[7:0]) : fifo_data_q;
        wrreq_d      = push && !fifo_full;
        sample_cnt_d = sample_cnt_q + {15'd0, wrreq_d};
        overrun_d    = overrun_q | (push && fifo_full) | (drdy_fall && in_read);
        cfg_done_d   = cfg_done_q | (state_q == ST_SETTLE && tmr_done);
    end

    always_ff @(posedge mclk or negedge i_rest_n) begin
        if (!i_rest_n) begin
            state_q      <= ST_RST_PULSE;
            wr_idx_q     <= '0;
            hi_q         <= '0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            sync3_q      <= 1'b1;
            db_out_q     <= '0;
            db_oe_q      <= 1'b0;
            r_n_w_q      <= 1'b1;
            cs_n_q       <= 1'b1;
            o_rest_n_q   <= 1'b0;
            fifo_data_q  <= '0;
            wrreq_q      <= 1'b0;
            cfg_done_q   <= 1'b0;
            overrun_q    <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            hi_q         <= hi_d;
            sync1_q      <= drdy_n;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            db_out_q     <= db_out_d;
            db_oe_q      <= db_oe_d;
            r_n_w_q      <= r_n_w_d;
            cs_n_q       <= cs_n_d;
            o_rest_n_q   <= o_rest_n_d;
            fifo_data_q  <= fifo_data_d;
            wrreq_q      <= wrreq_d;
            cfg_done_q   <= cfg_done_d;
            overrun_q    <= overrun_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign db_out     = db_out_q;
    assign db_oe      = db_oe_q;
    assign r_n_w      = r_n_w_q;
    assign cs_n       = cs_n_q;
    assign o_rest_n   = o_rest_n_q;
    assign fifo_data  = fifo_data_q;
    assign wrreq      = wrreq_q;
    assign cfg_done   = cfg_done_q;
    assign overrun    = overrun_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_ad7760_stream_ctrl.sv
// Bench for ad7760_stream_ctrl: bus model serves random read words, a
// scoreboard checks every FIFO write against a transaction-level model.
module tb_ad7760_stream_ctrl;

    logic        mclk = 1'b0;
    logic        i_rest_n = 1'b0;
    logic        command = 1'b0;
    logic        drdy_n = 1'b1;
    logic [15:0] db_in = 16'h0;
    logic        fifo_full = 1'b0;
    logic [15:0] db_out;
    logic        db_oe, r_n_w, cs_n, o_rest_n, wrreq, cfg_done, overrun;
    logic [31:0] fifo_data;
    logic [15:0] sample_cnt;

    typedef struct packed {
        logic [31:0] word;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] rd_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          model_cnt = 0;
    logic        model_ovr = 1'b0;
    logic        prev_cs = 1'b1;
    logic [15:0] cfg_exp [4] = '{16'h0001, 16'h0000, 16'h0002, 16'h0022};

    always #5 mclk = ~mclk;

    ad7760_stream_ctrl dut (
        .mclk(mclk), .i_rest_n(i_rest_n), .command(command), .drdy_n(drdy_n),
        .db_in(db_in), .db_out(db_out), .db_oe(db_oe), .r_n_w(r_n_w), .cs_n(cs_n),
        .o_rest_n(o_rest_n), .fifo_data(fifo_data), .wrreq(wrreq),
        .fifo_full(fifo_full), .cfg_done(cfg_done), .overrun(overrun),
        .sample_cnt(sample_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ADC bus model: each new read access presents the next queued word.
    always @(negedge mclk) begin
        if (!cs_n && r_n_w && prev_cs) begin
            if (rd_q.size() > 0) db_in = rd_q.pop_front();
            else                 db_in = 16'hDEAD;
        end
        prev_cs = cs_n;
    end

    // Scoreboard monitor.
    always @(negedge mclk) begin
        if (i_rest_n && wrreq === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_wrreq: got wrreq=1 data=%h expected no write", fifo_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("fifo_data", fifo_data, e.word);
                chk("sample_cnt_at_push", {16'h0, sample_cnt}, {16'h0, e.cnt});
            end
        end
    end

    task automatic chk_reset();
        chk("rst_o_rest_n", {31'h0, o_rest_n}, 32'h0);
        chk("rst_cs_n", {31'h0, cs_n}, 32'h1);
        chk("rst_r_n_w", {31'h0, r_n_w}, 32'h1);
        chk("rst_db_oe", {31'h0, db_oe}, 32'h0);
        chk("rst_db_out", {16'h0, db_out}, 32'h0);
        chk("rst_wrreq", {31'h0, wrreq}, 32'h0);
        chk("rst_fifo_data", fifo_data, 32'h0);
        chk("rst_cfg_done", {31'h0, cfg_done}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        chk("rst_sample_cnt", {16'h0, sample_cnt}, 32'h0);
    endtask

    // Called on the negedge where reset is released.
    task automatic check_config();
        int cnt;
        logic [15:0] prev_db;
        cnt = 0;
        while (o_rest_n === 1'b0 && cnt < 100) begin cnt++; @(negedge mclk); end
        chk("rest_low_cycles", cnt, 4);
        for (int w = 0; w < 4; w++) begin
            cnt = 0;
            prev_db = db_out;
            while (cs_n !== 1'b0 && cnt < 200) begin
                prev_db = db_out; cnt++; @(negedge mclk);
            end
            if (cnt >= 200) chk("cfg_cs_timeout", 1, 0);
            chk("cfg_word", {16'h0, db_out}, {16'h0, cfg_exp[w]});
            chk("cfg_setup", {16'h0, prev_db}, {16'h0, cfg_exp[w]});
            chk("cfg_r_n_w", {31'h0, r_n_w}, 32'h0);
            chk("cfg_db_oe", {31'h0, db_oe}, 32'h1);
            cnt = 0;
            while (cs_n === 1'b0 && cnt < 100) begin cnt++; @(negedge mclk); end
            chk("cfg_cs_low", cnt, 8);
            chk("cfg_hold", {16'h0, db_out}, {16'h0, cfg_exp[w]});
            chk("cfg_done_early", {31'h0, cfg_done}, 32'h0);
        end
        cnt = 0;
        while (cfg_done !== 1'b1 && cnt < 100) begin cnt++; @(negedge mclk); end
        chk("settle_to_done", cnt, 14);
    endtask

    task automatic pulse_drdy();
        drdy_n = 1'b0;
        repeat (3) @(negedge mclk);
        drdy_n = 1'b1;
    endtask

    // One sample transaction through the reference model.
    task automatic do_read(input logic [15:0] hi, input logic [15:0] lo, input logic full);
        rd_q.push_back(hi);
        rd_q.push_back(lo);
        if (full) model_ovr = 1'b1;
        else begin
            model_cnt++;
            exp_q.push_back('{word: {hi, lo}, cnt: 16'(model_cnt)});
        end
        fifo_full = full;
        pulse_drdy();
        repeat (40) @(negedge mclk);
        fifo_full = 1'b0;
        chk("sample_cnt", {16'h0, sample_cnt}, 32'(model_cnt & 16'hFFFF));
        chk("overrun", {31'h0, overrun}, {31'h0, model_ovr});
        chk("pending_words", exp_q.size() + rd_q.size(), 0);
    endtask

    task automatic reset_model();
        exp_q.delete();
        rd_q.delete();
        model_cnt = 0;
        model_ovr = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowcnt;
        // command and a held-low drdy during configuration must be ignored
        command = 1'b1;
        drdy_n  = 1'b0;
        repeat (3) @(negedge mclk);
        chk_reset();
        i_rest_n = 1'b1;
        check_config();
        drdy_n = 1'b1;
        repeat (5) @(negedge mclk);
        chk("ovr_after_cfg", {31'h0, overrun}, 32'h0);

        do_read(16'h1234, 16'h56A5, 1'b0);
        for (int i = 0; i < 8; i++) do_read(16'($urandom), 16'($urandom), 1'b0);

        // command drops mid-read: word completes, later pulses are ignored
        rd_q.push_back(16'hBEEF); rd_q.push_back(16'hC0DE);
        model_cnt++;
        exp_q.push_back('{word: 32'hBEEFC0DE, cnt: 16'(model_cnt)});
        pulse_drdy();
        repeat (7) @(negedge mclk);
        command = 1'b0;
        repeat (40) @(negedge mclk);
        chk("cmd_off_pushed", exp_q.size() + rd_q.size(), 0);
        pulse_drdy();
        lowcnt = 0;
        repeat (40) begin @(negedge mclk); if (cs_n === 1'b0) lowcnt++; end
        chk("idle_no_read", lowcnt, 0);
        chk("idle_cnt", {16'h0, sample_cnt}, 32'(model_cnt));
        command = 1'b1;
        repeat (3) @(negedge mclk);

        // reset asserted in the middle of RD_HI
        rd_q.push_back(16'h1111); rd_q.push_back(16'h2222);
        pulse_drdy();
        repeat (4) @(negedge mclk);
        chk("in_rd_hi_cs", {31'h0, cs_n}, 32'h0);
        #2 i_rest_n = 1'b0;
        #1 chk_reset();
        reset_model();
        @(negedge mclk);
        i_rest_n = 1'b1;
        check_config();
        repeat (3) @(negedge mclk);

        // FIFO full on push: dropped, overrun set
        do_read(16'hAAAA, 16'h5555, 1'b1);

        // second drdy edge lands in RD_LO: overrun, current word still pushed
        @(negedge mclk);
        i_rest_n = 1'b0;
        reset_model();
        @(negedge mclk);
        i_rest_n = 1'b1;
        check_config();
        repeat (3) @(negedge mclk);
        rd_q.push_back(16'h0F0F); rd_q.push_back(16'h3C3C);
        model_cnt++;
        exp_q.push_back('{word: 32'h0F0F3C3C, cnt: 16'(model_cnt)});
        pulse_drdy();
        repeat (17) @(negedge mclk);
        pulse_drdy();
        repeat (40) @(negedge mclk);
        chk("dbl_edge_overrun", {31'h0, overrun}, 32'h1);
        chk("dbl_edge_pushed", exp_q.size() + rd_q.size(), 0);
        chk("dbl_edge_cnt", {16'h0, sample_cnt}, 32'h1);
        model_ovr = 1'b1;

        for (int i = 0; i < 8; i++)
            do_read(16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ad7760_stream_ctrl.md
AD7760_STREAM_CTRL -- requirements
Module: ad7760_stream_ctrl

Interface
REQ-001 SHALL have parameter NUM_CFG, default 2, number of control-register writes issued after reset (1..8).
REQ-002 SHALL have parameter CFG_TABLE, default {16'h0001,16'h0000,16'h0002,16'h0022}, packed address/value pairs, pair 0 first.
REQ-003 SHALL have parameter RST_LOW_CYC, default 4, o_rest_n low time in mclk cycles (min 2).
REQ-004 SHALL have parameter STROBE_CYC, default 8, cs_n low time per bus access, and the same count for the cs_n-high gap after it (min 2).
REQ-005 SHALL have parameter SETTLE_CYC, default 6, idle mclk cycles after the last config write.
REQ-006 SHALL have ports: mclk in 1 clock; i_rest_n in 1 reset, one clock, asynchronous, active-low.
REQ-007 SHALL have ports: command in 1 stream enable; drdy_n in 1 ADC data-ready (asynchronous); db_in in 16 ADC bus read data.
REQ-008 SHALL have ports: db_out out 16 bus write data; db_oe out 1 bus drive enable; r_n_w out 1; cs_n out 1; o_rest_n out 1 ADC reset.
REQ-009 SHALL have ports: fifo_data out 32 {24-bit sample, 8-bit status}; wrreq out 1; fifo_full in 1.
REQ-010 SHALL have ports: cfg_done out 1; overrun out 1 sticky; sample_cnt out 16.

Function
REQ-011 SHALL pass drdy_n through a 2-flop synchroniser and act only on the synchronised falling edge.
REQ-012 SHALL sequence states RST_PULSE -> RST_WAIT -> WR_ADDR -> WR_GAP -> WR_VAL -> WR_GAP -> (next pair or SETTLE) -> IDLE -> WAIT_DRDY -> RD_HI -> RD_GAP -> RD_LO -> PUSH -> WAIT_DRDY.
REQ-013 RST_PULSE SHALL hold o_rest_n low for RST_LOW_CYC cycles; RST_WAIT SHALL hold o_rest_n high, cs_n high for RST_LOW_CYC cycles.
REQ-014 WR_ADDR/WR_VAL SHALL drive cs_n=0, r_n_w=0, db_oe=1, db_out=table word for STROBE_CYC cycles; db_out SHALL be stable one cycle before cs_n falls and until one cycle after it rises.
REQ-015 WR_GAP SHALL drive cs_n=1 for STROBE_CYC cycles; the pair index SHALL advance after each WR_VAL gap, and SETTLE SHALL follow when the index reaches NUM_CFG.
REQ-016 cfg_done SHALL assert on SETTLE exit and stay high until reset.
REQ-017 IDLE SHALL go to WAIT_DRDY when command=1, and SHALL otherwise hold cs_n=1, db_oe=0.
REQ-018 On a drdy falling edge in WAIT_DRDY, RD_HI SHALL drive cs_n=0, r_n_w=1, db_oe=0 for STROBE_CYC cycles and capture db_in on the last cycle as sample[23:8].
REQ-019 RD_LO SHALL repeat REQ-018, capturing db_in[15:8] as sample[7:0] and db_in[7:0] as status.
REQ-020 PUSH SHALL last one cycle and SHALL present fifo_data; wrreq=1 iff fifo_full=0; sample_cnt SHALL increment (wrapping at 16'hFFFF) only when wrreq=1.
REQ-021 If fifo_full=1 in PUSH, the word SHALL be dropped and overrun SHALL set.
REQ-022 A drdy falling edge during RD_HI..PUSH SHALL set overrun and SHALL NOT restart the read in progress.
REQ-023 command deasserting mid-read SHALL complete the read and PUSH, then go to IDLE; command deasserting in WAIT_DRDY SHALL go to IDLE the next cycle.
REQ-024 command SHALL be ignored before cfg_done.
REQ-025 fifo_data SHALL hold its last pushed value outside PUSH.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 i_rest_n low SHALL force immediately, in any state: state=RST_PULSE, o_rest_n=0, cs_n=1, r_n_w=1, db_oe=0, db_out=0, wrreq=0, fifo_data=0, cfg_done=0, overrun=0, sample_cnt=0, counters=0, synchroniser=1.
REQ-028 After release the full reset/config sequence SHALL rerun.

Structure
REQ-029 A shared package ad7760_pkg SHALL hold the state enumeration, the default control addresses/values and the 32-bit packing field positions.
REQ-030 A sub-module ad7760_bus_strobe (cs_n low/gap timer with done pulse) SHALL be instantiated once and shared by write and read accesses.

Verification
REQ-031 Reset release with defaults -> o_rest_n low 4 cycles; writes 0001,0000,0002,0022 each with 8-cycle cs_n low; cfg_done high after 6 settle cycles.
REQ-032 command=1, drdy_n pulse, bus model returning 16'h1234 then 16'h56A5 -> one wrreq pulse with fifo_data=32'h123456A5, sample_cnt=1.
REQ-033 fifo_full=1 during PUSH -> wrreq stays 0, overrun=1, sample_cnt unchanged.
REQ-034 Second drdy falling edge during RD_LO -> overrun=1; the current word still pushes.
REQ-035 i_rest_n asserted mid-RD_HI -> all outputs at reset values in the same cycle; config reruns after release.
REQ-036 command=0 mid-read -> the word pushes, then IDLE; later drdy pulses produce no wrreq.
